// File: rtl/pattern_frame_writer_pkg.sv
// Shared types, CRC constants and the word-parallel CRC-16-CCITT helper for the
// pattern frame writer.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_HSTRIPE = 2'd1,
        PAT_VBAR    = 2'd2,
        PAT_CHECK   = 2'd3
    } pat_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    localparam int unsigned CRC_W          = 16;
    localparam int unsigned CRC_MAX_DATA_W = 64;
    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC16_INIT = 16'hFFFF;

    // Folds the low nbits of data into crc_in, most significant bit first.
    function automatic logic [CRC_W-1:0] crc16_word(
        input logic [CRC_W-1:0]          crc_in,
        input logic [CRC_MAX_DATA_W-1:0] data,
        input int unsigned               nbits
    );
        logic [CRC_W-1:0] crc;
        logic             fb;
        logic [5:0]       idx;
        crc = crc_in;
        for (int unsigned k = 0; k < CRC_MAX_DATA_W; k++) begin
            if (k < nbits) begin
                idx = 6'(nbits - 1 - k);
                fb  = crc[CRC_W-1] ^ data[idx];
                crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/pattern_frame_writer_if.sv
// Framebuffer write port: valid/ready handshake carrying a word address and data.
interface pattern_frame_writer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/pattern_frame_writer_pos_counter.sv
// Raster position tracker: column/row/address counters plus stripe and bar
// parity sub-counters, so the pattern never needs a divider.
module pattern_pos_counter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_LINES      = 600,
    parameter int unsigned PIX_PER_WORD = 16,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned STRIPE_H     = 50,
    parameter int unsigned BAR_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_c,
    output logic              nxt_row_par_c,
    output logic              nxt_col_par_c
);

    localparam int unsigned WPL   = H_PIXELS / PIX_PER_WORD;
    localparam int unsigned COL_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned STR_W = (STRIPE_H > 1) ? $clog2(STRIPE_H) : 1;
    localparam int unsigned BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [STR_W-1:0]  stripe_q, stripe_d;
    logic [BAR_CW-1:0] bar_q, bar_d;
    logic              row_par_q, row_par_d;
    logic              col_par_q, col_par_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic col_wrap, bar_wrap, stripe_wrap;

    assign col_wrap    = (col_q == COL_W'(WPL - 1));
    assign bar_wrap    = (bar_q == BAR_CW'(BAR_W - 1));
    assign stripe_wrap = (stripe_q == STR_W'(STRIPE_H - 1));

    // Next raster position; parities restart at each line and each frame.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        stripe_d  = stripe_q;
        bar_d     = bar_q;
        row_par_d = row_par_q;
        col_par_d = col_par_q;
        addr_d    = addr_q;
        if (clear_i) begin
            col_d     = '0;
            row_d     = '0;
            stripe_d  = '0;
            bar_d     = '0;
            row_par_d = 1'b0;
            col_par_d = 1'b0;
            addr_d    = ADDR_W'(BASE_ADDR);
        end else if (adv_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_wrap) begin
                col_d     = '0;
                bar_d     = '0;
                col_par_d = 1'b0;
                row_d     = row_q + ROW_W'(1);
                if (stripe_wrap) begin
                    stripe_d  = '0;
                    row_par_d = ~row_par_q;
                end else begin
                    stripe_d = stripe_q + STR_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                if (bar_wrap) begin
                    bar_d     = '0;
                    col_par_d = ~col_par_q;
                end else begin
                    bar_d = bar_q + BAR_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            stripe_q  <= '0;
            bar_q     <= '0;
            row_par_q <= 1'b0;
            col_par_q <= 1'b0;
            addr_q    <= ADDR_W'(BASE_ADDR);
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            stripe_q  <= stripe_d;
            bar_q     <= bar_d;
            row_par_q <= row_par_d;
            col_par_q <= col_par_d;
            addr_q    <= addr_d;
        end
    end

    assign addr_o        = addr_q;
    assign last_c        = col_wrap && (row_q == ROW_W'(V_LINES - 1));
    assign nxt_row_par_c = row_par_d;
    assign nxt_col_par_c = col_par_d;

endmodule

// File: rtl/pattern_frame_writer.sv
// Fills a packed framebuffer with a selectable test pattern over a valid/ready port.
// Define PATTERN_FRAME_CRC_EN to accumulate a CRC-16-CCITT of each completed frame.
module pattern_frame_writer
    import pattern_gen_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_LINES      = 600,
    parameter int unsigned PIX_PER_WORD = 16,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned STRIPE_H     = 50,
    parameter int unsigned BAR_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [1:0]              mode_i,
    input  logic [DATA_W-1:0]       fg_word_i,
    input  logic [DATA_W-1:0]       bg_word_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CRC_W-1:0]        frame_crc_o,
    pattern_frame_writer_if.master  wr
);

    fill_state_e       state_q, state_d;
    pat_mode_e         mode_q, mode_d;
    logic [DATA_W-1:0] fg_q, fg_d;
    logic [DATA_W-1:0] bg_q, bg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;

    logic              clear_c;
    logic              accept_c;
    logic              last_c;
    logic              nxt_row_par_c;
    logic              nxt_col_par_c;
    logic [ADDR_W-1:0] addr_c;

    assign clear_c  = (state_q == IDLE) && start_i;
    assign accept_c = (state_q == FILL) && valid_q && wr.wr_ready;

    pattern_pos_counter #(
        .ADDR_W       (ADDR_W),
        .H_PIXELS     (H_PIXELS),
        .V_LINES      (V_LINES),
        .PIX_PER_WORD (PIX_PER_WORD),
        .BASE_ADDR    (BASE_ADDR),
        .STRIPE_H     (STRIPE_H),
        .BAR_W        (BAR_W)
    ) u_pos (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (clear_c),
        .adv_i         (accept_c),
        .addr_o        (addr_c),
        .last_c        (last_c),
        .nxt_row_par_c (nxt_row_par_c),
        .nxt_col_par_c (nxt_col_par_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks the final accept, so an aborted frame never reaches DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FILL;
            FILL: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (accept_c && last_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data for the following word is chosen from the counter's next parities.
    always_comb begin
        logic sel_bg;
        mode_d  = mode_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        data_d  = data_q;
        busy_d  = (state_d == FILL);
        valid_d = (state_d == FILL);
        done_d  = (state_d == DONE);
        sel_bg  = 1'b0;
        case (mode_q)
            PAT_SOLID:   sel_bg = 1'b0;
            PAT_HSTRIPE: sel_bg = nxt_row_par_c;
            PAT_VBAR:    sel_bg = nxt_col_par_c;
            PAT_CHECK:   sel_bg = nxt_row_par_c ^ nxt_col_par_c;
            default:     sel_bg = 1'b0;
        endcase
        if (clear_c) begin
            mode_d = pat_mode_e'(mode_i);
            fg_d   = fg_word_i;
            bg_d   = bg_word_i;
            data_d = fg_word_i;
        end else if (accept_c && !last_c) begin
            data_d = sel_bg ? bg_q : fg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= PAT_SOLID;
            fg_q    <= '0;
            bg_q    <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

`ifdef PATTERN_FRAME_CRC_EN
    logic [CRC_W-1:0] crc_run_q, crc_run_d;
    logic [CRC_W-1:0] frame_crc_q, frame_crc_d;

    // Running CRC covers every accepted word; the frame result is published on entry to DONE.
    always_comb begin
        crc_run_d   = crc_run_q;
        frame_crc_d = frame_crc_q;
        if (clear_c) begin
            crc_run_d = CRC16_INIT;
        end else if (accept_c) begin
            crc_run_d = crc16_word(crc_run_q, CRC_MAX_DATA_W'(data_q), DATA_W);
        end
        if ((state_q == FILL) && (state_d == DONE)) begin
            frame_crc_d = crc_run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_run_q   <= CRC16_INIT;
            frame_crc_q <= '0;
        end else begin
            crc_run_q   <= crc_run_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc_o = frame_crc_q;
`else
    assign frame_crc_o = '0;
`endif

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_c;
    assign wr.wr_data  = data_q;

endmodule

// File: tb/tb_pattern_frame_writer.sv
// Randomised bench for pattern_frame_writer: a raster-index reference model is
// compared against the DUT every cycle, with literal spot checks pinning the model.
module tb_pattern_frame_writer;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned H_PIXELS     = 64;
    localparam int unsigned V_LINES      = 4;
    localparam int unsigned PIX_PER_WORD = 16;
    localparam int unsigned BASE_ADDR    = 32'h100;
    localparam int unsigned STRIPE_H     = 2;
    localparam int unsigned BAR_W        = 1;
    localparam int unsigned WPL          = H_PIXELS / PIX_PER_WORD;
    localparam int unsigned TOTAL        = WPL * V_LINES;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fg = 16'h0;
    logic [15:0] bg = 16'h0;
    logic        busy;
    logic        done;
    logic [15:0] frame_crc;

    pattern_frame_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_if ();

    pattern_frame_writer #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .H_PIXELS (H_PIXELS), .V_LINES (V_LINES),
        .PIX_PER_WORD (PIX_PER_WORD), .BASE_ADDR (BASE_ADDR), .STRIPE_H (STRIPE_H), .BAR_W (BAR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .abort_i     (abort),
        .mode_i      (mode),
        .fg_word_i   (fg),
        .bg_word_i   (bg),
        .busy_o      (busy),
        .done_o      (done),
        .frame_crc_o (frame_crc),
        .wr          (wr_if)
    );

    always #5 clk = ~clk;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern from raster position by plain division.
    function automatic logic [15:0] ref_pat(input int unsigned m, input logic [15:0] f,
                                            input logic [15:0] b, input int unsigned idx);
        int unsigned row, col;
        bit rp, cp;
        row = idx / WPL;
        col = idx % WPL;
        rp  = ((row / STRIPE_H) % 2) == 1;
        cp  = ((col / BAR_W) % 2) == 1;
        case (m)
            0:       return f;
            1:       return rp ? b : f;
            2:       return cp ? b : f;
            default: return (rp ^ cp) ? b : f;
        endcase
    endfunction

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [31:0] d, input int n);
        logic [15:0] r;
        r = c;
        for (int i = n - 1; i >= 0; i--) begin
            if (r[15] ^ d[5'(i)]) r = (r << 1) ^ 16'h1021;
            else                  r = r << 1;
        end
        return r;
    endfunction

    // Reference model: phase 0 idle, 1 filling, 2 done pulse.
    int unsigned m_phase = 0, m_idx = 0, m_mode = 0, m_accepts = 0;
    logic [15:0] m_fg = 0, m_bg = 0, m_crc = 16'hFFFF, m_fcrc = 0;
    bit          m_fresh = 0, m_live = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_phase = 0; m_idx = 0; m_fcrc = 16'h0; m_fresh = 1; m_live = 1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_mode = 32'(mode); m_fg = fg; m_bg = bg; m_idx = 0;
                    m_crc = 16'hFFFF; m_phase = 1; m_fresh = 0;
                end
                1: begin
                    if (wr_if.wr_ready) begin
                        m_crc = ref_crc(m_crc, 32'(ref_pat(m_mode, m_fg, m_bg, m_idx)), 16);
                        m_accepts++;
                    end
                    if (abort) m_phase = 0;
                    else if (wr_if.wr_ready) begin
                        if (m_idx == TOTAL - 1) begin
                            m_phase = 2; m_fcrc = m_crc;
                        end else begin
                            m_idx++;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    logic [15:0] obs_data [64];
    logic [15:0] obs_addr [64];
    int unsigned obs_n = 0, busy_cyc = 0, done_cnt = 0;

    // Per-cycle compare against the model, mid-cycle.
    initial forever begin
        logic [15:0] exp_crc;
        @(negedge clk);
        if (m_live) begin
            chk("wr_valid", 32'(wr_if.wr_valid), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            if (m_phase == 1) begin
                chk("wr_addr", 32'(wr_if.wr_addr), 32'(16'(BASE_ADDR + m_idx)));
                chk("wr_data", 32'(wr_if.wr_data), 32'(ref_pat(m_mode, m_fg, m_bg, m_idx)));
            end
            if (m_fresh) begin
                chk("reset_addr", 32'(wr_if.wr_addr), BASE_ADDR);
                chk("reset_data", 32'(wr_if.wr_data), 32'h0);
            end
`ifdef PATTERN_FRAME_CRC_EN
            exp_crc = m_fcrc;
`else
            exp_crc = 16'h0;
`endif
            chk("frame_crc", 32'(frame_crc), 32'(exp_crc));
            if (wr_if.wr_valid && wr_if.wr_ready && obs_n < 64) begin
                obs_data[obs_n] = wr_if.wr_data;
                obs_addr[obs_n] = wr_if.wr_addr;
                obs_n++;
            end
            if (busy) busy_cyc++;
            if (done) done_cnt++;
        end
    end

    bit rnd_ready = 0, scramble = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) wr_if.wr_ready = 1'($urandom_range(0, 1));
        if (scramble) begin
            mode = 2'($urandom_range(0, 3)); fg = 16'($urandom); bg = 16'($urandom);
        end
    endtask

    task automatic pulse_start(input int unsigned m, input logic [15:0] f, input logic [15:0] b);
        mode = 2'(m); fg = f; bg = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        while (m_phase != 0 && n < budget) begin
            tick(); n++;
        end
        chk("wait_bound", 32'(n < budget), 32'h1);
        tick();
    endtask

    task automatic clear_obs();
        obs_n = 0; busy_cyc = 0; done_cnt = 0;
    endtask

    initial begin
        logic [15:0] exp_b [16];
        logic [15:0] c;
        logic [7:0]  msg [9];
        int unsigned n;
        exp_b = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555,
                  16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        wr_if.wr_ready = 1'b1;

        // Model CRC pinned to the standard CCITT-FALSE check value.
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = ref_crc(c, 32'(msg[i]), 8);
        chk("model_crc_check", 32'(c), 32'h29B1);

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(wr_if.wr_valid), 32'h0);
        chk("rst_addr", 32'(wr_if.wr_addr), 32'h100);

        // Solid fill at full rate.
        clear_obs();
        pulse_start(0, 16'hFFFF, 16'h0000);
        wait_idle(100);
        chk("A_busy_cycles", busy_cyc, 16);
        chk("A_done_pulses", done_cnt, 1);
        chk("A_accepts", obs_n, 16);
        chk("A_first_addr", 32'(obs_addr[0]), 32'h100);
        chk("A_last_addr", 32'(obs_addr[15]), 32'h10F);
        chk("A_last_data", 32'(obs_data[15]), 32'hFFFF);

        // Checkerboard against a hand-written table.
        clear_obs();
        pulse_start(3, 16'hAAAA, 16'h5555);
        wait_idle(100);
        for (int i = 0; i < 16; i++) chk("B_check_word", 32'(obs_data[i]), 32'(exp_b[i]));

        // Stripes under random back-pressure with inputs churning mid-frame.
        clear_obs();
        pulse_start(1, 16'h1234, 16'hABCD);
        rnd_ready = 1; scramble = 1;
        wait_idle(400);
        rnd_ready = 0; scramble = 0; wr_if.wr_ready = 1'b1;
        chk("C_accepts", obs_n, 16);
        chk("C_done_pulses", done_cnt, 1);
        chk("C_row1_fg", 32'(obs_data[7]), 32'h1234);
        chk("C_row2_bg", 32'(obs_data[8]), 32'hABCD);

        // Abort after five accepts, then a clean restart.
        tick();
        clear_obs();
        pulse_start(2, 16'h00FF, 16'hFF00);
        n = 0;
        while (obs_n < 5 && n < 50) begin tick(); n++; end
        chk("D_wait_bound", 32'(n < 50), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("D_valid_after_abort", 32'(wr_if.wr_valid), 32'h0);
        tick();
        chk("D_no_done", done_cnt, 0);
        pulse_start(2, 16'h00FF, 16'hFF00);
        chk("D_restart_addr", 32'(wr_if.wr_addr), 32'h100);
        wait_idle(100);
        chk("D_done_after_restart", done_cnt, 1);

        // Start while busy is ignored; reset mid-frame returns to reset values.
        clear_obs();
        pulse_start(1, 16'h0F0F, 16'hF0F0);
        repeat (3) tick();
        pulse_start(0, 16'h7777, 16'h8888);
        repeat (2) tick();
        chk("E_addr_continues", 32'(wr_if.wr_addr), 32'h106);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("E_rst_valid", 32'(wr_if.wr_valid), 32'h0);
        chk("E_rst_busy", 32'(busy), 32'h0);
        chk("E_rst_addr", 32'(wr_if.wr_addr), 32'h100);
        chk("E_rst_data", 32'(wr_if.wr_data), 32'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("E_no_done", done_cnt, 0);

        // Random frames; abort held during a DONE pulse must not cancel it.
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            pulse_start($urandom_range(0, 3), 16'($urandom), 16'($urandom));
            rnd_ready = 1;
            n = 0;
            while (m_phase != 2 && n < 400) begin tick(); n++; end
            chk("F_wait_bound", 32'(n < 400), 32'h1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            rnd_ready = 0; wr_if.wr_ready = 1'b1;
            tick();
            chk("F_done_pulses", done_cnt, 1);
            chk("F_accepts", obs_n, 16);
        end

        // CRC of an all-zero frame.
        clear_obs();
        pulse_start(0, 16'h0000, 16'hFFFF);
        n = 0;
        while (m_phase != 2 && n < 100) begin tick(); n++; end
        c = 16'hFFFF;
        for (int i = 0; i < 16; i++) c = ref_crc(c, 32'h0, 16);
`ifndef PATTERN_FRAME_CRC_EN
        c = 16'h0;
`endif
        chk("G_zero_frame_crc", 32'(frame_crc), 32'(c));
        wait_idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
